// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request/response and shared-ALU lines of the multiply sequencer.
//   slave  : seen by mdu_seq (takes start/op/a/b and ALU result, drives the rest)
//   master : seen by the core (or bench) that issues requests and hosts the ALU
// Signals:
//   start, op, a[31:0], b[31:0]     request
//   busy, done, hi[31:0], lo[31:0]  status / 64-bit product
//   alu_x, alu_y, alu_ctr[3:0]      ALU operand/control lines owned while busy
//   alu_z, alu_cf                   ALU result and carry-out
interface mdu_seq_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [3:0]  alu_ctr;
  logic [31:0] alu_z;
  logic        alu_cf;

  modport slave (
    input  start, op, a, b, alu_z, alu_cf,
    output busy, done, hi, lo, alu_x, alu_y, alu_ctr
  );

  modport master (
    output start, op, a, b, alu_z, alu_cf,
    input  busy, done, hi, lo, alu_x, alu_y, alu_ctr
  );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative 32x32->64 shift-add multiplier that borrows the shared
// execute-stage ALU instead of owning an adder. One add per cycle, 32 cycles.
// Optional feature macro: MDU_SIGNED_EN -- when defined, op=1 (mult) runs a
// signed multiply via sign-magnitude pre/post negation (latency 36); when
// undefined, every request is unsigned (latency 32) and op is ignored.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mdu_seq_if.slave: start/op/a/b in, busy/done/hi/lo out,
//          alu_x/alu_y/alu_ctr out to the ALU, alu_z/alu_cf back from it
module mdu_seq (
  input  logic     clk,
  input  logic     rst_n,
  mdu_seq_if.slave bus
);

  localparam logic [3:0] ALU_ADDU = 4'b0010;
`ifdef MDU_SIGNED_EN
  localparam logic [3:0] ALU_SUBU = 4'b0011;
`endif

`ifdef MDU_SIGNED_EN
  typedef enum logic [2:0] {
    IDLE, NEG_A, NEG_B, ITER, NEG_LO, NEG_HI, DONE
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE, ITER, DONE
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] alu_x, alu_y;
  logic [3:0]  alu_ctr;
`ifdef MDU_SIGNED_EN
  logic        neg_q, neg_d;
  logic        lo_z_q, lo_z_d;
  // op is latched at acceptance so the live op input cannot steer an
  // operation already in flight.
  logic        sgn_q, sgn_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
`ifdef MDU_SIGNED_EN
      neg_q   <= 1'b0;
      lo_z_q  <= 1'b0;
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
`ifdef MDU_SIGNED_EN
      neg_q   <= neg_d;
      lo_z_q  <= lo_z_d;
      sgn_q   <= sgn_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    alu_x   = '0;
    alu_y   = '0;
    alu_ctr = ALU_ADDU;
`ifdef MDU_SIGNED_EN
    neg_d   = neg_q;
    lo_z_d  = lo_z_q;
    sgn_d   = sgn_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = bus.a;
          lo_d    = bus.b;
          hi_d    = '0;
          cnt_d   = '0;
`ifdef MDU_SIGNED_EN
          neg_d   = bus.op & (bus.a[31] ^ bus.b[31]);
          sgn_d   = bus.op;
          state_d = bus.op ? NEG_A : ITER;
`else
          state_d = ITER;
`endif
        end
      end
`ifdef MDU_SIGNED_EN
      // Take magnitudes; 0x80000000 negates to itself, which is exactly
      // 2^31 when read as unsigned, so no special case is needed.
      NEG_A: begin
        alu_ctr = ALU_SUBU;
        alu_y   = mcand_q;
        if (mcand_q[31]) mcand_d = bus.alu_z;
        state_d = NEG_B;
      end
      NEG_B: begin
        alu_ctr = ALU_SUBU;
        alu_y   = lo_q;
        if (lo_q[31]) lo_d = bus.alu_z;
        state_d = ITER;
      end
`endif
      ITER: begin
        alu_x = hi_q;
        alu_y = lo_q[0] ? mcand_q : 32'h0;
        // 65-bit {carry, sum, multiplier} shifted right by one.
        hi_d  = {bus.alu_cf, bus.alu_z[31:1]};
        lo_d  = {bus.alu_z[0], lo_q[31:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
`ifdef MDU_SIGNED_EN
          state_d = sgn_q ? NEG_LO : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef MDU_SIGNED_EN
      // 64-bit negate in two halves: lo = 0 - lo, hi = ~hi + (lo was 0).
      NEG_LO: begin
        alu_ctr = ALU_SUBU;
        alu_y   = lo_q;
        lo_z_d  = (lo_q == 32'h0);
        if (neg_q) lo_d = bus.alu_z;
        state_d = NEG_HI;
      end
      NEG_HI: begin
        alu_x   = ~hi_q;
        alu_y   = {31'b0, lo_z_q};
        if (neg_q) hi_d = bus.alu_z;
        state_d = DONE;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.alu_x   = alu_x;
  assign bus.alu_y   = alu_y;
  assign bus.alu_ctr = alu_ctr;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_seq_if bus ();
  mdu_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Behavioural ALU: addu / subu with carry-out of the add.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum    = {1'b0, bus.alu_x} + {1'b0, bus.alu_y};
    bus.alu_cf = alu_sum[32];
    if (bus.alu_ctr == 4'b0011) bus.alu_z = bus.alu_x - bus.alu_y;
    else                        bus.alu_z = alu_sum[31:0];
  end

  typedef struct {
    logic [63:0] prod;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic [63:0] r;
    r = {32'b0, a} * {32'b0, b};
`ifdef MDU_SIGNED_EN
    if (op) r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
`else
    if (op) r = {32'b0, a} * {32'b0, b};
`endif
    return r;
  endfunction

  function automatic int lat_of(input logic op);
`ifdef MDU_SIGNED_EN
    return op ? 37 : 33;
`else
    return op ? 33 : 33;
`endif
  endfunction

  // Issue one request and follow it. repulse_at: cycle to re-pulse start
  // (0 = never). reset_at: cycle to pulse rst_n (0 = never).
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic op,
                     input int repulse_at, input int reset_at);
    exp_t e;
    bit   seen;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.op = op;
    e.prod = model(a, b, op);
    e.lat  = lat_of(op);
    sb.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    seen = 0;
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == repulse_at + 1 && repulse_at != 0) bus.start = 1'b0;
      if (cyc == repulse_at) begin
        bus.start = 1'b1; bus.op = ~op;
      end
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", {63'b0, bus.busy}, 64'd0);
        check("rst_done", {63'b0, bus.done}, 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        #2 rst_n = 1'b1;
        void'(sb.pop_front());
        for (int k = 0; k < 45; k++) begin
          @(negedge clk);
          if (bus.done) check("rst_no_done", {63'b0, bus.done}, 64'd0);
        end
        return;
      end
      if (!bus.busy) check("busy_during", {63'b0, bus.busy}, 64'd1);
      if (bus.done) begin
        seen = 1;
        e = sb.pop_front();
        check("latency", 64'(cyc), 64'(e.lat));
        check("product", {bus.hi, bus.lo}, e.prod);
        // start while in DONE must be ignored.
        bus.start = 1'b1; bus.a = 32'h0; bus.b = 32'h0;
        @(negedge clk);
        bus.start = 1'b0;
        check("idle_busy", {63'b0, bus.busy}, 64'd0);
        check("idle_done", {63'b0, bus.done}, 64'd0);
        check("hold", {bus.hi, bus.lo}, e.prod);
      end
    end
    if (!seen) begin
      checks++; errors++;
      $error("FAIL timeout observed=no_done expected=done");
      void'(sb.pop_front());
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    #12;
    check("reset_busy", {63'b0, bus.busy}, 64'd0);
    check("reset_done", {63'b0, bus.done}, 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_ctr", {60'b0, bus.alu_ctr}, 64'h2);
    rst_n = 1'b1;

    run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 0);
    check("uns_max_const", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    run(32'hFFFFFFFD, 32'h00000005, 1'b1, 0, 0);
`ifdef MDU_SIGNED_EN
    check("neg3x5_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFF1);
`endif
    run(32'h80000000, 32'h80000000, 1'b1, 0, 0);
    run(32'h00000000, 32'hFFFFFFF9, 1'b1, 0, 0);
    check("zero_neg", {bus.hi, bus.lo}, 64'd0);
    run(32'h00010000, 32'hFFFF0000, 1'b1, 0, 0);
    run(32'h12345678, 32'h9ABCDEF0, 1'b0, 10, 0);
    run(32'hDEADBEEF, 32'h0BADF00D, 1'b1, 0, 15);
    run(32'd3, 32'd4, 1'b0, 0, 0);
    check("three_x_four", {32'b0, bus.lo}, 64'd12);
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 0);
    for (int i = 0; i < 4; i++)
      run($urandom, $urandom, 1'($urandom_range(0, 1)), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative 32×32→64 multiply sequencer that drives the shared ALU instead of instantiating its own adder. On `start` it owns the ALU operand/control lines, performs one shift-add step per cycle, and leaves a 64-bit product on `hi`/`lo`. It sits beside the ALU in the execute stage and serves `mult`/`multu`. The core multiplexes ALU ownership using `busy`.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = unsigned (`multu`), 1 = signed (`mult`).
- `a`  in  32  multiplicand; sampled with `start`.
- `b`  in  32  multiplier; sampled with `start`.
- `busy`  out  1  high from the cycle after `start` acceptance through the DONE state.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid.
- `hi`  out  32  product [63:32].
- `lo`  out  32  product [31:0].
- `alu_x`  out  32  ALU operand x.
- `alu_y`  out  32  ALU operand y.
- `alu_ctr`  out  4  ALU op: 4'b0010 (addu) or 4'b0011 (subu).
- `alu_z`  in  32  ALU result.
- `alu_cf`  in  1  ALU Carryflag. Only consumed during addu, where it equals carry-out.

## Operation
Internal registers:
- `mcand[31:0]`: multiplicand.
- `hi`, `lo`: accumulator and multiplier shift register.
- `cnt[5:0]`: iteration counter.
- `neg`: result sign.
- `lo_z`: flag, set when `lo` is zero before negation.

State machine:
- **IDLE**
  - If `start`: `mcand←a`, `lo←b`, `hi←0`, `cnt←0`.
  - `neg←op&(a[31]^b[31])`.
  - Next state: NEG_A if `op` (signed), else ITER.
- **NEG_A**
  - ALU subu, x=0, y=`mcand`.
  - If `mcand[31]`: `mcand←alu_z`.
  - Next state: NEG_B.
- **NEG_B**
  - ALU subu, x=0, y=`lo`.
  - If `lo[31]`: `lo←alu_z`.
  - Next state: ITER.
- **ITER** (32 cycles)
  - ALU addu, x=`hi`, y=`lo[0] ? mcand : 0`.
  - `{hi,lo} ← {alu_cf, alu_z, lo[31:1]}`, i.e. a 65-bit value whose top 64 bits are kept.
  - `cnt++`.
  - Exit when `cnt==31`: next state is NEG_LO if `op`, else DONE.
- **NEG_LO**
  - ALU subu, x=0, y=`lo`.
  - `lo_z←(lo==0)`.
  - If `neg`: `lo←alu_z`.
  - Next state: NEG_HI.
- **NEG_HI**
  - ALU addu, x=`~hi`, y=`{31'b0, lo_z}`.
  - If `neg`: `hi←alu_z`.
  - Next state: DONE.
- **DONE**
  - `done=1`; next state: IDLE.

ALU drive:
- The ALU lines are combinational from state and registers.
- In IDLE and DONE: x=0, y=0, ctr=4'b0010.

Arithmetic and boundary rules:
- Signed magnitudes are treated as unsigned after NEG_A/NEG_B. Example: `0x80000000` stays `0x80000000` and is multiplied correctly as 2^31.
- Negation steps run for every signed op regardless of sign, so signed latency is fixed.
- A negative result with `lo==0` propagates the +1 into `hi` via `lo_z`.
- A zero product with `neg=1` yields `hi=lo=0`.
- `start` outside IDLE is ignored; the operation in flight is unaffected.
- `start` asserted during DONE is ignored. A new request is accepted in IDLE, i.e. no earlier than one cycle after `done`.
- `hi`/`lo` hold their value after DONE until the next acceptance. At acceptance, `hi` clears and `lo` loads `b`.

## Timing
Reset (`rst_n` low, asynchronous): state=IDLE, and `busy`, `done`, `hi`, `lo`, `cnt`, `neg`, `lo_z` all 0. This applies mid-operation too; the operation is abandoned with no `done`.

Latency, from the `start`-accepting edge to the edge that enters DONE:
- Unsigned: 32 cycles. `done` is high during cycle 33 after acceptance.
- Signed: 36 cycles. `done` is high during cycle 37.

`busy` rises the cycle after acceptance and falls on return to IDLE. The core must not drive the ALU while `busy`=1.

## Configuration
- `MDU_SIGNED_EN` defined:
  - `op` is honoured.
  - NEG_A, NEG_B, NEG_LO and NEG_HI exist.
  - Signed latency is 36.
- `MDU_SIGNED_EN` undefined:
  - `op` is ignored; every request is unsigned.
  - The NEG_* states, `neg` and `lo_z` are not built.
  - ALU ctr is always 4'b0010.
  - Latency is always 32.

## Test plan
- Unsigned `a=0xFFFFFFFF`, `b=0xFFFFFFFF`, `op=0` -> `hi=0xFFFFFFFE`, `lo=0x00000001`, `done` in cycle 33, `busy` high for cycles 1–33.
- Signed `a=0xFFFFFFFD` (−3), `b=5`, `op=1` -> `hi=0xFFFFFFFF`, `lo=0xFFFFFFF1`, `done` in cycle 37.
- Signed `a=b=0x80000000` -> `hi=0x40000000`, `lo=0`.
- Signed `a=0`, `b=0xFFFFFFF9` (−7) -> `hi=0`, `lo=0`.
- Signed `a=0x00010000`, `b=0xFFFF0000` (−2^16) -> `hi=0xFFFFFFFF`, `lo=0`, exercising the `lo_z` carry into `hi`.
- Reset and re-issue sequence:
  - `start` pulsed again at cycle 10 of a multiply -> ignored, first result correct.
  - `rst_n` pulsed low at cycle 15 -> `busy=0`, `hi=lo=0`, no `done`.
  - A fresh `3×4` -> `lo=12`.
  - Without `MDU_SIGNED_EN`: `op=1`, `a=b=0xFFFFFFFF` -> `hi=0xFFFFFFFE`, `lo=1`, `done` in cycle 33.
